// File: rtl/command_decoder.sv
// Command decoder: executes NOP/WRITE/READ/STATUS command words against a small
// config register file and queues a reply for a busy-gated byte sender.
//
// state   | meaning
// IDLE    | waiting for a command strobe
// DECODE  | execute latched command, load reply, flag errors
// WAIT_TX | reply queued, waiting for sender to be free
// SEND    | one-cycle reply request
// HOLD    | covers the sender's busy-rise latency
module command_decoder #(
  parameter int          WORD_SIZE       = 32,
  parameter int          INPUT_DATA_SIZE = 40,
  parameter int          SIZE_WORD       = 3,
  parameter int          NUM_REGS        = 4,
  parameter logic [7:0]  ACK_CHAR        = 8'h4B,
  parameter logic [7:0]  ERR_CHAR        = 8'h45
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [INPUT_DATA_SIZE-1:0]    control_value,
  input  logic                          valid_control_value,
  input  logic                          busy,
  input  logic [WORD_SIZE-1:0]          status_in,
  output logic [WORD_SIZE-1:0]          data_to_send,
  output logic [SIZE_WORD-1:0]          size_of_data,
  output logic                          valid_data,
  output logic [NUM_REGS*WORD_SIZE-1:0] config_out,
  output logic                          cmd_error,
  output logic [7:0]                    drop_count
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {IDLE, DECODE, WAIT_TX, SEND, HOLD} state_t;

  state_t                     state, next_state;
  logic [INPUT_DATA_SIZE-1:0] cmd;
  logic [WORD_SIZE-1:0]       regs [NUM_REGS];
  logic [3:0]                 opcode;
  logic [3:0]                 addr;
  logic [AW-1:0]              addr_idx;
  logic                       addr_ok;
  logic                       is_nop;
  logic                       is_write;
  logic                       reply_err;
  logic [WORD_SIZE-1:0]       reply_word;
  logic [SIZE_WORD-1:0]       reply_size;

  assign opcode   = cmd[INPUT_DATA_SIZE-1 -: 4];
  assign addr     = cmd[INPUT_DATA_SIZE-5 -: 4];
  assign addr_idx = addr[AW-1:0];
  assign addr_ok  = ({28'd0, addr} < 32'(NUM_REGS));

  always_comb begin
    is_nop     = 1'b0;
    is_write   = 1'b0;
    reply_err  = 1'b0;
    reply_word = '0;
    reply_size = '0;
    case (opcode)
      4'h0: is_nop = 1'b1;
      4'h1: begin
        if (addr_ok) begin
          is_write   = 1'b1;
          reply_word = WORD_SIZE'(ACK_CHAR);
          reply_size = SIZE_WORD'(1);
        end else begin
          reply_err = 1'b1;
        end
      end
      4'h2: begin
        if (addr_ok) begin
          reply_word = regs[addr_idx];
          reply_size = SIZE_WORD'(4);
        end else begin
          reply_err = 1'b1;
        end
      end
      4'h3: begin
        reply_word = status_in;
        reply_size = SIZE_WORD'(4);
      end
      default: reply_err = 1'b1;
    endcase
    if (reply_err) begin
      reply_word = WORD_SIZE'(ERR_CHAR);
      reply_size = SIZE_WORD'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (valid_control_value) next_state = DECODE;
      DECODE:  next_state = is_nop ? IDLE : WAIT_TX;
      WAIT_TX: if (!busy) next_state = SEND;
      SEND:    next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    valid_data = (state == SEND);
    cmd_error  = (state == DECODE) && reply_err;
  end

  // Reply fields are loaded only when leaving DECODE, so they stay stable
  // through WAIT_TX/SEND/HOLD regardless of later register or status changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd          <= '0;
      data_to_send <= '0;
      size_of_data <= '0;
      drop_count   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (valid_control_value) begin
        if (state == IDLE)              cmd        <= control_value;
        else if (drop_count != 8'hFF)   drop_count <= drop_count + 8'd1;
      end
      if (state == DECODE && !is_nop) begin
        data_to_send <= reply_word;
        size_of_data <= reply_size;
        if (is_write) regs[addr_idx] <= cmd[WORD_SIZE-1:0];
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_cfg
    assign config_out[k*WORD_SIZE +: WORD_SIZE] = regs[k];
  end

endmodule

// File: tb/tb_command_decoder.sv
// Directed bench for command_decoder: a vector table for single commands plus
// hand-written sequences for backpressure, dropping, saturation and reset.
module tb_command_decoder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [39:0]  control_value;
  logic         valid_control_value;
  logic         busy;
  logic [31:0]  status_in;
  logic [31:0]  data_to_send;
  logic [2:0]   size_of_data;
  logic         valid_data;
  logic [127:0] config_out;
  logic         cmd_error;
  logic [7:0]   drop_count;

  int tests = 0;
  int fails = 0;

  command_decoder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .control_value       (control_value),
    .valid_control_value (valid_control_value),
    .busy                (busy),
    .status_in           (status_in),
    .data_to_send        (data_to_send),
    .size_of_data        (size_of_data),
    .valid_data          (valid_data),
    .config_out          (config_out),
    .cmd_error           (cmd_error),
    .drop_count          (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [39:0] cmd;
    logic [31:0] status;
    logic        exp_reply;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [2:0]  exp_size;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One command with busy=0; watches 8 cycles after the strobe.
  task automatic run_vec(input vec_t v);
    int pulses = 0;
    int errs   = 0;
    int lat    = -1;
    logic [31:0] d = '0;
    logic [2:0]  s = '0;
    status_in           = v.status;
    control_value       = v.cmd;
    valid_control_value = 1'b1;
    step();
    valid_control_value = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (cmd_error) errs++;
      if (valid_data) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          d   = data_to_send;
          s   = size_of_data;
        end
      end
      step();
    end
    check({v.name, " pulses"}, 128'(pulses), v.exp_reply ? 128'd1 : 128'd0);
    check({v.name, " errors"}, 128'(errs), v.exp_err ? 128'd1 : 128'd0);
    if (v.exp_reply) begin
      check({v.name, " latency"}, 128'(lat), 128'd3);
      check({v.name, " data"}, 128'(d), 128'(v.exp_data));
      check({v.name, " size"}, 128'(s), 128'(v.exp_size));
    end
  endtask

  initial begin
    int pulses;
    int lat;
    logic [31:0] d;

    vecs[0]  = '{"write r2",   40'h1_2_DEADBEEF, 32'h0, 1'b1, 1'b0, 32'h0000004B, 3'd1};
    vecs[1]  = '{"read r2",    40'h2_2_00000000, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 3'd4};
    vecs[2]  = '{"read r7",    40'h2_7_00000000, 32'h0, 1'b1, 1'b1, 32'h00000045, 3'd1};
    vecs[3]  = '{"write r0",   40'h1_0_00001111, 32'h0, 1'b1, 1'b0, 32'h0000004B, 3'd1};
    vecs[4]  = '{"write r3",   40'h1_3_A5A55A5A, 32'h0, 1'b1, 1'b0, 32'h0000004B, 3'd1};
    vecs[5]  = '{"read r0",    40'h2_0_00000000, 32'h0, 1'b1, 1'b0, 32'h00001111, 3'd4};
    vecs[6]  = '{"read r3",    40'h2_3_00000000, 32'h0, 1'b1, 1'b0, 32'hA5A55A5A, 3'd4};
    vecs[7]  = '{"opcode 5",   40'h5_0_12345678, 32'h0, 1'b1, 1'b1, 32'h00000045, 3'd1};
    vecs[8]  = '{"write r4",   40'h1_4_FFFFFFFF, 32'h0, 1'b1, 1'b1, 32'h00000045, 3'd1};
    vecs[9]  = '{"status",     40'h3_9_00000000, 32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D, 3'd4};
    vecs[10] = '{"nop",        40'h0_1_FFFFFFFF, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0};

    rst_n               = 1'b0;
    control_value       = '0;
    valid_control_value = 1'b0;
    busy                = 1'b0;
    status_in           = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset config_out", config_out, 128'd0);
    check("reset valid_data", 128'(valid_data), 128'd0);
    check("reset cmd_error", 128'(cmd_error), 128'd0);
    check("reset drop_count", 128'(drop_count), 128'd0);
    check("reset data", 128'(data_to_send), 128'd0);
    check("reset size", 128'(size_of_data), 128'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
      if (i == 0) check("write r2 config", 128'(config_out[95:64]), 128'h DEADBEEF);
      if (i == 2) check("read r7 config", config_out, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    end
    check("table config_out", config_out, {32'hA5A55A5A, 32'hDEADBEEF, 32'h0, 32'h00001111});
    check("table drop_count", 128'(drop_count), 128'd0);

    // Backpressure: busy held 20 cycles during STATUS
    busy                = 1'b1;
    status_in           = 32'h12345678;
    control_value       = 40'h3_0_00000000;
    valid_control_value = 1'b1;
    step();
    valid_control_value = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_data) pulses++;
      if (i == 2) status_in = 32'h0;
      step();
    end
    check("bp no pulse while busy", 128'(pulses), 128'd0);
    check("bp data held", 128'(data_to_send), 128'h12345678);
    check("bp size held", 128'(size_of_data), 128'd4);
    busy   = 1'b0;
    pulses = 0;
    lat    = -1;
    d      = '0;
    for (int k = 0; k < 10; k++) begin
      if (valid_data) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          d   = data_to_send;
        end
      end
      step();
    end
    check("bp pulses", 128'(pulses), 128'd1);
    check("bp latency after busy", 128'(lat), 128'd1);
    check("bp data", 128'(d), 128'h12345678);

    // Second strobe one cycle after the first is dropped
    control_value       = 40'h1_1_11223344;
    valid_control_value = 1'b1;
    step();
    control_value       = 40'h1_1_99999999;
    step();
    valid_control_value = 1'b0;
    repeat (8) step();
    check("drop config r1", 128'(config_out[63:32]), 128'h11223344);
    check("drop count", 128'(drop_count), 128'd1);

    // Strobe during HOLD is dropped
    control_value       = 40'h2_1_00000000;
    valid_control_value = 1'b1;
    step();
    valid_control_value = 1'b0;
    pulses = 0;
    d      = '0;
    for (int k = 1; k <= 10; k++) begin
      if (valid_data) begin
        pulses++;
        d = data_to_send;
      end
      if (k == 4) begin
        control_value       = 40'h1_0_00000BAD;
        valid_control_value = 1'b1;
      end
      if (k == 5) valid_control_value = 1'b0;
      step();
    end
    check("hold pulses", 128'(pulses), 128'd1);
    check("hold read data", 128'(d), 128'h11223344);
    check("hold drop count", 128'(drop_count), 128'd2);
    check("hold r0 unchanged", 128'(config_out[31:0]), 128'h00001111);

    // Drop counter saturation
    busy                = 1'b1;
    control_value       = 40'h3_0_00000000;
    valid_control_value = 1'b1;
    repeat (301) step();
    valid_control_value = 1'b0;
    check("drop saturate", 128'(drop_count), 128'd255);
    busy = 1'b0;
    repeat (8) step();

    // Reset while in WAIT_TX
    busy                = 1'b1;
    control_value       = 40'h2_1_00000000;
    valid_control_value = 1'b1;
    step();
    valid_control_value = 1'b0;
    step();
    step();
    check("pre-reset data", 128'(data_to_send), 128'h11223344);
    rst_n = 1'b0;
    #2;
    check("rst config_out", config_out, 128'd0);
    check("rst drop_count", 128'(drop_count), 128'd0);
    check("rst data", 128'(data_to_send), 128'd0);
    check("rst size", 128'(size_of_data), 128'd0);
    check("rst valid_data", 128'(valid_data), 128'd0);
    step();
    rst_n  = 1'b1;
    busy   = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (valid_data) pulses++;
      step();
    end
    check("post-reset no pulse", 128'(pulses), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/command_decoder.md
COMMAND_DECODER -- requirements
Module: command_decoder

Interface
REQ-001 Parameters SHALL be, one per line, as follows.
- WORD_SIZE, 32: reply payload width.
- INPUT_DATA_SIZE, 40: command word width.
- SIZE_WORD, 3: reply byte-count width.
- NUM_REGS, 4: number of config registers.
- ACK_CHAR, 8'h4B: write-acknowledge byte.
- ERR_CHAR, 8'h45: error reply byte.
REQ-002 Ports SHALL be, one per line, as follows.
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- control_value, in, INPUT_DATA_SIZE: command word from the UART command receiver.
- valid_control_value, in, 1: one-cycle strobe qualifying control_value.
- busy, in, 1: reply sender busy.
- status_in, in, WORD_SIZE: live status word.
- data_to_send, out, WORD_SIZE: reply payload, LSB byte sent first.
- size_of_data, out, SIZE_WORD: reply byte count.
- valid_data, out, 1: one-cycle reply request.
- config_out, out, NUM_REGS*WORD_SIZE: flattened config registers; register k at bits [k*32+31:k*32].
- cmd_error, out, 1: one-cycle pulse on a rejected command.
- drop_count, out, 8: commands dropped while not IDLE.

Function
REQ-003 Command fields SHALL be: opcode = control_value[39:36], addr = control_value[35:32], data = control_value[31:0].
REQ-004 The FSM SHALL have the states IDLE, DECODE, WAIT_TX, SEND and HOLD.
REQ-005 In IDLE, valid_control_value=1 SHALL latch control_value and move to DECODE on the next edge.
REQ-006 Opcode 0x0 (NOP) SHALL return from DECODE to IDLE with no reply.
REQ-007 Opcode 0x1 (WRITE) with addr<NUM_REGS SHALL update register[addr]<=data at the edge ending DECODE, then queue a reply of ACK_CHAR with size 1.
REQ-008 Opcode 0x2 (READ) with addr<NUM_REGS SHALL queue a reply of register[addr] with size 4.
REQ-009 Opcode 0x3 (STATUS) SHALL sample status_in in DECODE and queue it with size 4; addr is ignored.
REQ-010 Any other opcode, or WRITE/READ with addr>=NUM_REGS, SHALL pulse cmd_error for 1 cycle in DECODE, leave all registers unchanged, and queue ERR_CHAR with size 1.
REQ-011 For a 1-byte reply, data_to_send upper bits SHALL be zero.
REQ-012 DECODE with a reply queued SHALL move to WAIT_TX.
REQ-013 WAIT_TX SHALL remain while busy=1 and SHALL move to SEND once busy=0.
REQ-014 SEND SHALL assert valid_data for exactly 1 cycle, then move to HOLD.
REQ-015 HOLD SHALL last exactly 1 cycle, covering the sender's busy-rise latency, then return to IDLE.
REQ-016 data_to_send and size_of_data SHALL hold stable from WAIT_TX entry until IDLE is re-entered.
REQ-017 The minimum latency from a valid_control_value strobe (cycle N) to valid_data SHALL be N+3 when busy=0.
REQ-018 A strobe arriving in any state other than IDLE SHALL be dropped, and drop_count SHALL increment, saturating at 255.
REQ-019 A strobe on the cycle HOLD returns to IDLE SHALL be counted as dropped.
REQ-020 A strobe in IDLE SHALL be accepted.
REQ-021 valid_data and cmd_error SHALL never be asserted on consecutive cycles for the same command beyond the stated pulses.
REQ-022 config_out SHALL be registered, with no combinational path from control_value.

Reset
REQ-023 While rst_n=0, the block SHALL asynchronously force: FSM to IDLE; config registers, data_to_send, size_of_data and drop_count to 0; valid_data and cmd_error to 0.
REQ-024 Deassertion of rst_n mid-reply SHALL leave no pending reply and no valid_data pulse.

Verification
REQ-025 WRITE: control_value=40'h1_2_DEADBEEF strobe, busy=0 -> config_out[95:64]=32'hDEADBEEF; valid_data at N+3 with data_to_send=32'h0000004B, size 1.
REQ-026 READ: after REQ-025, strobe 40'h2_2_00000000 -> data_to_send=32'hDEADBEEF, size 4, single valid_data pulse.
REQ-027 Error: strobe 40'h2_7_00000000 -> cmd_error pulses once, data_to_send=32'h00000045, size 1, config_out unchanged.
REQ-028 Backpressure: busy=1 held 20 cycles during a STATUS command with status_in=32'h12345678 -> no valid_data until busy falls; then one pulse, data_to_send=32'h12345678.
REQ-029 Drop: a second strobe sent 1 cycle after the first -> only the first is executed; drop_count=1.
REQ-030 Reset: rst_n pulsed low while in WAIT_TX -> IDLE, config_out=0, no valid_data afterward.
